// File: rtl/stream_demux_if.sv
// Valid/ready bundle for the 1:N stream demux: one input stream in, N output streams out.
// The producer/consumer side uses the master modport; the demux uses slave.
interface stream_demux_if #(
    parameter int DATAW = 4,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [DATAW-1:0]        data_in;
    logic [SELW-1:0]         sel_in;
    logic                    valid_in;
    logic                    ready_out;
    logic [N-1:0][DATAW-1:0] data_out;
    logic [N-1:0]            valid_out;
    logic [N-1:0]            ready_in;
    logic                    err_out;

    modport master (
        output data_in, sel_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out, err_out
    );

    modport slave (
        input  data_in, sel_in, valid_in, ready_in,
        output ready_out, data_out, valid_out, err_out
    );
endinterface

// File: rtl/stream_demux.sv
// 1:N stream demux with a 2-entry FIFO per output port, so one stalled consumer
// only blocks beats addressed to it. Out-of-range selects are dropped and flagged.
module stream_demux #(
    parameter int DATAW = 4,
    parameter int N     = 4
) (
    input  logic          clk,
    input  logic          rst,
    stream_demux_if.slave bus
);
    logic                    w_in_range;
    logic                    w_sel_full;
    logic                    w_ready;
    logic                    w_accept;
    logic [N-1:0]            w_full;
    logic [N-1:0]            w_push;
    logic [N-1:0]            w_pop;
    logic [N-1:0]            w_valid;
    logic [N-1:0][DATAW-1:0] w_data;
    logic                    r_err;

    assign w_in_range = (int'(bus.sel_in) < N);

    // Select the addressed port's full flag without indexing past N-1.
    always_comb begin
        w_sel_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (int'(bus.sel_in) == i) begin
                w_sel_full = w_full[i];
            end
        end
    end

    assign w_ready  = !rst && (!w_in_range || !w_sel_full);
    assign w_accept = bus.valid_in && w_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_port
            logic [DATAW-1:0] r_mem [2];
            logic             r_wr_ptr;
            logic             r_rd_ptr;
            logic [1:0]       r_count;

            assign w_full[gi]  = (r_count == 2'd2);
            assign w_valid[gi] = (r_count != 2'd0);
            assign w_data[gi]  = r_mem[r_rd_ptr];
            assign w_push[gi]  = w_accept && w_in_range && (int'(bus.sel_in) == gi);
            assign w_pop[gi]   = w_valid[gi] && bus.ready_in[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[0] <= '0;
                    r_mem[1] <= '0;
                    r_wr_ptr <= 1'b0;
                    r_rd_ptr <= 1'b0;
                    r_count  <= 2'd0;
                end else begin
                    if (w_push[gi]) begin
                        r_mem[r_wr_ptr] <= bus.data_in;
                        r_wr_ptr        <= ~r_wr_ptr;
                    end
                    if (w_pop[gi]) begin
                        r_rd_ptr <= ~r_rd_ptr;
                    end
                    // Push and pop together leave the count unchanged.
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_count <= r_count + 2'd1;
                        2'b01:   r_count <= r_count - 2'd1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            a_count_max: assert property (@(posedge clk) disable iff (rst) r_count <= 2'd2);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_in_range;
        end
    end

    assign bus.ready_out = w_ready;
    assign bus.valid_out = w_valid;
    assign bus.data_out  = w_data;
    assign bus.err_out   = r_err;
endmodule
